// File: rtl/rr_arb_rsp_router_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_rsp_router_pkg
// Shared helpers for the round-robin arbiter response router slice.
// The only item here is the index-width helper. The router and any future
// arbiter-side blocks use it to size the requester index the same way.
// Ports: none (package).
// ---------------------------------------------------------------------------
package rr_arb_rsp_router_pkg;

   // A single requester still needs a one-bit index so the ID FIFO never
   // collapses to zero width.
   function automatic int unsigned idx_width(input int unsigned num_in);
      return (num_in > 1) ? $clog2(num_in) : 1;
   endfunction

endpackage

// File: rtl/rr_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// rr_arb_id_fifo
// In-order ID FIFO. It records which requester won each accepted request, so
// that the in-order slave responses can be steered back to their owner.
// The depth does not have to be a power of two; both pointers wrap explicitly.
//
// Ports:
//   clk_i    clock, all state on the rising edge
//   rst_ni   asynchronous active-low reset
//   flush    synchronous clear of pointers and count (wins over push/pop)
//   push     write data_in at the write pointer (ignored when full)
//   pop      advance the read pointer (ignored when empty)
//   data_in  ID to store
//   data_out ID at the read pointer (head)
//   full     count == Depth
//   empty    count == 0
//   usage    current occupancy
// ---------------------------------------------------------------------------
module rr_arb_id_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 2,
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush,
   input  logic                push,
   input  logic                pop,
   input  logic [Width-1:0]    data_in,
   output logic [Width-1:0]    data_out,
   output logic                full,
   output logic                empty,
   output logic [CntWidth-1:0] usage
);

   logic [Width-1:0]    mem_q [Depth];
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [CntWidth-1:0] count_q;
   logic                do_push;
   logic                do_pop;

   // Pointer wrap for a depth that is not necessarily a power of two.
   function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Status comes from the registered count only. This keeps full/empty free
   // of any combinational path back from push or pop.
   assign full     = (count_q == CntWidth'(Depth));
   assign empty    = (count_q == '0);
   assign usage    = count_q;
   assign data_out = mem_q[rd_ptr_q];

   // Self-protect against overflow and underflow, even though the router
   // already gates push with full and pop with empty.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointer and occupancy bookkeeping. Flush discards everything and takes
   // priority over a push or pop in the same cycle. A simultaneous push and
   // pop moves both pointers and leaves the count as it is.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage has no reset. An entry is only read after it has been written,
   // because empty masks the head until a push lands.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: rtl/rr_arb_rsp_router.sv
// ---------------------------------------------------------------------------
// rr_arb_rsp_router
// Sits right after the round-robin arbitration tree. It forwards the
// arbitrated request to a single slave without adding latency, and it
// remembers the winner index of every accepted request. It then steers the
// in-order slave responses back to the requester that owns them. When
// MaxTxns transactions are outstanding, it holds off the arbiter.
//
// Ports:
//   clk_i / rst_ni     clock, asynchronous active-low reset
//   flush_i            clear all outstanding IDs (no response may be in flight)
//   arb_req_i          arbitrated request
//   arb_idx_i          winning requester index
//   arb_data_i         arbitrated payload
//   arb_gnt_o          grant back to the arbiter
//   slv_req_o          request to slave
//   slv_data_o         payload to slave
//   slv_gnt_i          slave grant
//   rsp_valid_i        slave response valid
//   rsp_data_i         slave response payload
//   rsp_ready_o        response accepted by the addressed requester
//   mst_rsp_valid_o    per-requester response valid (onehot0)
//   mst_rsp_data_o     response payload broadcast to all requesters
//   mst_rsp_ready_i    per-requester response ready
//   outstanding_o      number of IDs currently held
// ---------------------------------------------------------------------------
module rr_arb_rsp_router
   import rr_arb_rsp_router_pkg::*;
#(
   parameter int unsigned NumIn    = 4,
   parameter int unsigned MaxTxns  = 4,
   parameter int unsigned ReqWidth = 32,
   parameter int unsigned RspWidth = 32,
   localparam int unsigned IdxWidth = idx_width(NumIn),
   localparam int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                arb_req_i,
   input  logic [IdxWidth-1:0] arb_idx_i,
   input  logic [ReqWidth-1:0] arb_data_i,
   output logic                arb_gnt_o,
   output logic                slv_req_o,
   output logic [ReqWidth-1:0] slv_data_o,
   input  logic                slv_gnt_i,
   input  logic                rsp_valid_i,
   input  logic [RspWidth-1:0] rsp_data_i,
   output logic                rsp_ready_o,
   output logic [NumIn-1:0]    mst_rsp_valid_o,
   output logic [RspWidth-1:0] mst_rsp_data_o,
   input  logic [NumIn-1:0]    mst_rsp_ready_i,
   output logic [CntWidth-1:0] outstanding_o
);

   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   logic [IdxWidth-1:0] head_idx;

   // The request path is gated only by the registered full flag. A pop in the
   // same cycle cannot free a slot for this cycle's push. That avoids a
   // combinational path from the response side into the grant.
   assign slv_req_o  = arb_req_i & ~fifo_full;
   assign arb_gnt_o  = slv_gnt_i & ~fifo_full;
   assign slv_data_o = arb_data_i;
   assign fifo_push  = arb_req_i & arb_gnt_o;

   // A response belongs to the oldest outstanding ID. While the FIFO is empty,
   // nothing is routed or accepted. This includes the cycle in which the
   // first ID is being pushed.
   assign rsp_ready_o    = ~fifo_empty & mst_rsp_ready_i[head_idx];
   assign fifo_pop       = rsp_valid_i & rsp_ready_o;
   assign mst_rsp_data_o = rsp_data_i;

   // Demultiplex the response valid to the head owner only.
   always_comb begin
      mst_rsp_valid_o = '0;
      if (rsp_valid_i && !fifo_empty) begin
         mst_rsp_valid_o[head_idx] = 1'b1;
      end
   end

   rr_arb_id_fifo #(
      .Depth (MaxTxns),
      .Width (IdxWidth)
   ) u_id_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush    (flush_i),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .data_in  (arb_idx_i),
      .data_out (head_idx),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .usage    (outstanding_o)
   );

`ifndef SYNTHESIS
   logic req_wait_q;

   // Remembers that the arbiter was left waiting last cycle. Once raised, the
   // request must not be withdrawn before it is granted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_wait_q <= 1'b0;
      end else begin
         req_wait_q <= arb_req_i & ~arb_gnt_o & ~flush_i;
      end
   end

   // Protocol and structural checks, simulation only.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert ($onehot0(mst_rsp_valid_o));
         assert (outstanding_o <= CntWidth'(MaxTxns));
         assert (!(fifo_push && fifo_full));
         assert (!(rsp_valid_i && fifo_empty));
         assert (!req_wait_q || arb_req_i);
      end
   end
`endif

endmodule

// File: tb/tb_rr_arb_rsp_router.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_rsp_router
// Self-checking bench for rr_arb_rsp_router, using the default parameters
// (NumIn=4, MaxTxns=4). Every accepted request queues its expected
// requester index. Each routed response is compared against the front of
// that queue.
// ---------------------------------------------------------------------------
module tb_rr_arb_rsp_router;

   localparam int NUM_IN   = 4;
   localparam int MAX_TXNS = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        arb_req_i;
   logic [1:0]  arb_idx_i;
   logic [31:0] arb_data_i;
   logic        arb_gnt_o;
   logic        slv_req_o;
   logic [31:0] slv_data_o;
   logic        slv_gnt_i;
   logic        rsp_valid_i;
   logic [31:0] rsp_data_i;
   logic        rsp_ready_o;
   logic [3:0]  mst_rsp_valid_o;
   logic [31:0] mst_rsp_data_o;
   logic [3:0]  mst_rsp_ready_i;
   logic [2:0]  outstanding_o;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];

   rr_arb_rsp_router dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .arb_req_i       (arb_req_i),
      .arb_idx_i       (arb_idx_i),
      .arb_data_i      (arb_data_i),
      .arb_gnt_o       (arb_gnt_o),
      .slv_req_o       (slv_req_o),
      .slv_data_o      (slv_data_o),
      .slv_gnt_i       (slv_gnt_i),
      .rsp_valid_i     (rsp_valid_i),
      .rsp_data_i      (rsp_data_i),
      .rsp_ready_o     (rsp_ready_o),
      .mst_rsp_valid_o (mst_rsp_valid_o),
      .mst_rsp_data_o  (mst_rsp_data_o),
      .mst_rsp_ready_i (mst_rsp_ready_i),
      .outstanding_o   (outstanding_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock and update the scoreboard from the inputs driven this
   // cycle. A push needs a free slot as seen at the start of the cycle. A pop
   // needs a non-empty queue and a ready head owner. Flush clears everything.
   task automatic tick();
      bit push_m;
      bit pop_m;
      int idx_m;
      push_m = arb_req_i && slv_gnt_i && (exp_q.size() < MAX_TXNS);
      pop_m  = rsp_valid_i && (exp_q.size() > 0) && mst_rsp_ready_i[exp_q[0]];
      idx_m  = int'(arb_idx_i);
      @(posedge clk_i);
      if (flush_i) begin
         exp_q.delete();
      end else begin
         if (pop_m)  void'(exp_q.pop_front());
         if (push_m) exp_q.push_back(idx_m);
      end
      #1;
   endtask

   task automatic idle_inputs();
      flush_i         = 1'b0;
      arb_req_i       = 1'b0;
      arb_idx_i       = '0;
      arb_data_i      = '0;
      slv_gnt_i       = 1'b0;
      rsp_valid_i     = 1'b0;
      rsp_data_i      = '0;
      mst_rsp_ready_i = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b0;
      #3;
      if (outstanding_o !== 3'd0) begin
         failures++;
         $display("[TB] FAIL reset_outstanding got=%0d want=0", outstanding_o);
      end
      checks++;
      if (rsp_ready_o !== 1'b0 || mst_rsp_valid_o !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_rsp got rdy=%b vld=%b want rdy=0 vld=0000", rsp_ready_o, mst_rsp_valid_o);
      end
      checks++;
      arb_req_i = 1'b1;
      slv_gnt_i = 1'b1;
      #1;
      if (arb_gnt_o !== 1'b1 || slv_req_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_passthru got gnt=%b req=%b want 1 1", arb_gnt_o, slv_req_o);
      end
      checks++;
      idle_inputs();
      #1;
      if (arb_gnt_o !== 1'b0 || slv_req_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_passthru_low got gnt=%b req=%b want 0 0", arb_gnt_o, slv_req_o);
      end
      checks++;
      @(negedge clk_i);
      rst_ni = 1'b1;
      exp_q.delete();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_single();
      arb_req_i  = 1'b1;
      arb_idx_i  = 2'd2;
      arb_data_i = $urandom;
      slv_gnt_i  = 1'b1;
      #1;
      if (arb_gnt_o !== 1'b1 || slv_req_o !== 1'b1 || slv_data_o !== arb_data_i) begin
         failures++;
         $display("[TB] FAIL single_req got gnt=%b req=%b data=%h want 1 1 %h", arb_gnt_o, slv_req_o, slv_data_o, arb_data_i);
      end
      checks++;
      tick();
      arb_req_i = 1'b0;
      slv_gnt_i = 1'b0;
      if (outstanding_o !== 3'd1) begin
         failures++;
         $display("[TB] FAIL single_count got=%0d want=1", outstanding_o);
      end
      checks++;
      rsp_valid_i     = 1'b1;
      rsp_data_i      = 32'hCAFE_0002;
      mst_rsp_ready_i = 4'b0100;
      #1;
      if (mst_rsp_valid_o !== 4'(1 << exp_q[0]) || mst_rsp_valid_o !== 4'b0100) begin
         failures++;
         $display("[TB] FAIL single_route got=%b want=0100", mst_rsp_valid_o);
      end
      checks++;
      if (rsp_ready_o !== 1'b1 || mst_rsp_data_o !== 32'hCAFE_0002) begin
         failures++;
         $display("[TB] FAIL single_rsp got rdy=%b data=%h want 1 cafe0002", rsp_ready_o, mst_rsp_data_o);
      end
      checks++;
      tick();
      rsp_valid_i     = 1'b0;
      mst_rsp_ready_i = '0;
      if (outstanding_o !== 3'd0) begin
         failures++;
         $display("[TB] FAIL single_drain got=%0d want=0", outstanding_o);
      end
      checks++;
   endtask

   // Return responses with every ready high until the scoreboard is empty.
   // Each routed valid must match the scoreboard head.
   task automatic drain(input string tag);
      int n;
      n = 0;
      mst_rsp_ready_i = 4'b1111;
      while (exp_q.size() > 0 && n < 16) begin
         rsp_valid_i = 1'b1;
         rsp_data_i  = $urandom;
         #1;
         if (mst_rsp_valid_o !== 4'(1 << exp_q[0]) || rsp_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_route got vld=%b rdy=%b want vld=%b rdy=1", tag, mst_rsp_valid_o, rsp_ready_o, 4'(1 << exp_q[0]));
         end
         checks++;
         tick();
         n++;
      end
      rsp_valid_i     = 1'b0;
      mst_rsp_ready_i = '0;
      if (outstanding_o !== 3'd0 || exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL %s_drain got=%0d want=0 (pending model=%0d)", tag, outstanding_o, exp_q.size());
      end
      checks++;
   endtask

   task automatic test_full();
      for (int i = 0; i < MAX_TXNS; i++) begin
         arb_req_i  = 1'b1;
         arb_idx_i  = 2'(i);
         arb_data_i = $urandom;
         slv_gnt_i  = 1'b1;
         #1;
         if (arb_gnt_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_fill_gnt[%0d] got=%b want=1", i, arb_gnt_o);
         end
         checks++;
         tick();
      end
      arb_idx_i = 2'd0;
      #1;
      if (outstanding_o !== 3'd4 || arb_gnt_o !== 1'b0 || slv_req_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL full_block got cnt=%0d gnt=%b req=%b want 4 0 0", outstanding_o, arb_gnt_o, slv_req_o);
      end
      checks++;
      rsp_valid_i     = 1'b1;
      mst_rsp_ready_i = 4'b1111;
      #1;
      if (mst_rsp_valid_o !== 4'b0001 || rsp_ready_o !== 1'b1 || arb_gnt_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL full_pop got vld=%b rdy=%b gnt=%b want 0001 1 0", mst_rsp_valid_o, rsp_ready_o, arb_gnt_o);
      end
      checks++;
      tick();
      rsp_valid_i = 1'b0;
      #1;
      if (outstanding_o !== 3'd3 || arb_gnt_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL full_release got cnt=%0d gnt=%b want 3 1", outstanding_o, arb_gnt_o);
      end
      checks++;
      tick();
      arb_req_i = 1'b0;
      slv_gnt_i = 1'b0;
      drain("full");
   endtask

   task automatic test_in_order();
      logic [3:0] want [3];
      int idxs [3];
      idxs[0] = 3; idxs[1] = 1; idxs[2] = 3;
      want[0] = 4'b1000; want[1] = 4'b0010; want[2] = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         arb_req_i = 1'b1;
         arb_idx_i = 2'(idxs[i]);
         slv_gnt_i = 1'b1;
         tick();
      end
      arb_req_i       = 1'b0;
      slv_gnt_i       = 1'b0;
      mst_rsp_ready_i = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         rsp_valid_i = 1'b1;
         #1;
         if (mst_rsp_valid_o !== want[i]) begin
            failures++;
            $display("[TB] FAIL in_order[%0d] got=%b want=%b", i, mst_rsp_valid_o, want[i]);
         end
         checks++;
         tick();
      end
      rsp_valid_i = 1'b0;
      if (outstanding_o !== 3'd0) begin
         failures++;
         $display("[TB] FAIL in_order_drain got=%0d want=0", outstanding_o);
      end
      checks++;
   endtask

   task automatic test_backpressure();
      arb_req_i = 1'b1;
      arb_idx_i = 2'd1;
      slv_gnt_i = 1'b1;
      tick();
      arb_req_i       = 1'b0;
      slv_gnt_i       = 1'b0;
      rsp_valid_i     = 1'b1;
      mst_rsp_ready_i = 4'b1101;
      #1;
      if (mst_rsp_valid_o !== 4'b0010 || rsp_ready_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_stall got vld=%b rdy=%b want 0010 0", mst_rsp_valid_o, rsp_ready_o);
      end
      checks++;
      tick();
      if (outstanding_o !== 3'd1) begin
         failures++;
         $display("[TB] FAIL bp_hold got=%0d want=1", outstanding_o);
      end
      checks++;
      mst_rsp_ready_i = 4'b1111;
      #1;
      if (rsp_ready_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_release got rdy=%b want 1", rsp_ready_o);
      end
      checks++;
      tick();
      rsp_valid_i     = 1'b0;
      mst_rsp_ready_i = '0;
      if (outstanding_o !== 3'd0) begin
         failures++;
         $display("[TB] FAIL bp_pop got=%0d want=0", outstanding_o);
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2; i++) begin
         arb_req_i = 1'b1;
         arb_idx_i = 2'(i);
         slv_gnt_i = 1'b1;
         tick();
      end
      arb_idx_i       = 2'd2;
      rsp_valid_i     = 1'b1;
      mst_rsp_ready_i = 4'b1111;
      #1;
      if (arb_gnt_o !== 1'b1 || mst_rsp_valid_o !== 4'b0001 || rsp_ready_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_both got gnt=%b vld=%b rdy=%b want 1 0001 1", arb_gnt_o, mst_rsp_valid_o, rsp_ready_o);
      end
      checks++;
      tick();
      arb_idx_i = 2'd3;
      #1;
      if (outstanding_o !== 3'd2 || mst_rsp_valid_o !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL b2b_advance got cnt=%0d vld=%b want 2 0010", outstanding_o, mst_rsp_valid_o);
      end
      checks++;
      tick();
      rsp_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         arb_idx_i = 2'(i);
         tick();
      end
      arb_idx_i   = 2'd2;
      rsp_valid_i = 1'b1;
      #1;
      if (outstanding_o !== 3'd4 || arb_gnt_o !== 1'b0 || rsp_ready_o !== 1'b1 || mst_rsp_valid_o !== 4'(1 << exp_q[0])) begin
         failures++;
         $display("[TB] FAIL b2b_full got cnt=%0d gnt=%b rdy=%b vld=%b want 4 0 1 %b", outstanding_o, arb_gnt_o, rsp_ready_o, mst_rsp_valid_o, 4'(1 << exp_q[0]));
      end
      checks++;
      tick();
      rsp_valid_i = 1'b0;
      #1;
      if (outstanding_o !== 3'd3 || arb_gnt_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_full_pop got cnt=%0d gnt=%b want 3 1", outstanding_o, arb_gnt_o);
      end
      checks++;
      tick();
      arb_req_i = 1'b0;
      slv_gnt_i = 1'b0;
      drain("b2b");
   endtask

   task automatic test_flush();
      for (int i = 1; i <= 3; i++) begin
         arb_req_i = 1'b1;
         arb_idx_i = 2'(i);
         slv_gnt_i = 1'b1;
         tick();
      end
      arb_idx_i = 2'd0;
      flush_i   = 1'b1;
      #1;
      if (outstanding_o !== 3'd3) begin
         failures++;
         $display("[TB] FAIL flush_pre got=%0d want=3", outstanding_o);
      end
      checks++;
      tick();
      flush_i   = 1'b0;
      arb_req_i = 1'b0;
      slv_gnt_i = 1'b0;
      if (outstanding_o !== 3'd0) begin
         failures++;
         $display("[TB] FAIL flush_clear got=%0d want=0", outstanding_o);
      end
      checks++;
      // Probe the empty-FIFO routing between clock edges only.
      rsp_valid_i     = 1'b1;
      mst_rsp_ready_i = 4'b1111;
      #1;
      if (mst_rsp_valid_o !== 4'b0000 || rsp_ready_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flush_empty_rsp got vld=%b rdy=%b want 0000 0", mst_rsp_valid_o, rsp_ready_o);
      end
      checks++;
      rsp_valid_i = 1'b0;
      tick();
      arb_req_i = 1'b1;
      arb_idx_i = 2'd2;
      slv_gnt_i = 1'b1;
      tick();
      arb_req_i = 1'b0;
      slv_gnt_i = 1'b0;
      drain("flush");
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 2; i++) begin
         arb_req_i = 1'b1;
         arb_idx_i = 2'(i + 2);
         slv_gnt_i = 1'b1;
         tick();
      end
      arb_req_i = 1'b0;
      slv_gnt_i = 1'b0;
      #1;
      rst_ni = 1'b0;
      exp_q.delete();
      #1;
      if (outstanding_o !== 3'd0) begin
         failures++;
         $display("[TB] FAIL midrst_count got=%0d want=0", outstanding_o);
      end
      checks++;
      rsp_valid_i     = 1'b1;
      mst_rsp_ready_i = 4'b1111;
      #1;
      if (mst_rsp_valid_o !== 4'b0000 || rsp_ready_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_rsp got vld=%b rdy=%b want 0000 0", mst_rsp_valid_o, rsp_ready_o);
      end
      checks++;
      rsp_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      arb_req_i = 1'b1;
      arb_idx_i = 2'd1;
      slv_gnt_i = 1'b1;
      tick();
      arb_req_i = 1'b0;
      slv_gnt_i = 1'b0;
      drain("midrst");
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_in_order();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
